// File: rtl/vedic_pkg.sv
// Shared definitions for the pipelined Vedic multiplier: pipeline depth,
// per-stage control record and the elaboration-time width check.
package vedic_pkg;

    localparam int VEDIC_LATENCY = 3;

    // Control part of every pipeline stage record; data fields depend on
    // WIDTH and are declared alongside this in the top level.
    typedef struct packed {
        logic valid;
        logic sign;
    } stage_ctrl_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/vedic_mult_core.sv
// Purely combinational recursive Urdhva-Tiryagbhyam W x W multiplier.
// Splits into four half-width products down to a 2x2 bit-level leaf.
module vedic_mult_core #(
    parameter int W = 8
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p
);

    if (W == 2) begin : g_leaf
        logic c;
        assign p[0] = x[0] & y[0];
        assign p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        assign c    = (x[1] & y[0]) & (x[0] & y[1]);
        assign p[2] = (x[1] & y[1]) ^ c;
        assign p[3] = (x[1] & y[1]) & c;
    end else begin : g_rec
        localparam int H = W / 2;
        logic [W-1:0] hh, hl, lh, ll;

        vedic_mult_core #(.W(H)) u_hh (.x(x[W-1:H]), .y(y[W-1:H]), .p(hh));
        vedic_mult_core #(.W(H)) u_hl (.x(x[W-1:H]), .y(y[H-1:0]), .p(hl));
        vedic_mult_core #(.W(H)) u_lh (.x(x[H-1:0]), .y(y[W-1:H]), .p(lh));
        vedic_mult_core #(.W(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .p(ll));

        // {hh, ll} is hh << W plus ll, since ll never exceeds W bits.
        assign p = {hh, ll}
                 + ({{W{1'b0}}, hl} << H)
                 + ({{W{1'b0}}, lh} << H);
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Vedic multiplier with valid/ready flow control and
// per-beat signed/unsigned mode (sign-magnitude through the core).
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int HALF = WIDTH / 2;

    if (!is_pow2(WIDTH) || WIDTH < 4) begin : g_bad_width
        $error("vedic_mult_pipe: WIDTH must be a power of two >= 4");
    end

    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] mag_a;
        logic [WIDTH-1:0] mag_b;
    } s0_t;

    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] hh;
        logic [WIDTH-1:0] hl;
        logic [WIDTH-1:0] lh;
        logic [WIDTH-1:0] ll;
    } s1_t;

    typedef struct packed {
        stage_ctrl_t        ctrl;
        logic [2*WIDTH-1:0] prod;
    } s2_t;

    s0_t s0, s0_next;
    s1_t s1, s1_next;
    s2_t s2, s2_next;

    logic               advance;
    logic               signed_beat;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   hh_w, hl_w, lh_w, ll_w;

    // One stall signal for the whole pipe: nothing moves unless S2 can empty.
    assign advance   = !s2.ctrl.valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = s2.ctrl.valid;
    assign result    = s2.prod;

    // Magnitude of the most negative value wraps back to itself, which as
    // an unsigned WIDTH-bit number is exactly 2^(WIDTH-1).
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; here
        // each field is assigned unconditionally, so no latch can form.
        signed_beat        = SIGNED_EN && is_signed;
        s0_next.ctrl.valid = in_valid;
        s0_next.ctrl.sign  = signed_beat && (a[WIDTH-1] ^ b[WIDTH-1]);
        s0_next.mag_a      = (signed_beat && a[WIDTH-1]) ? -a : a;
        s0_next.mag_b      = (signed_beat && b[WIDTH-1]) ? -b : b;
    end

    vedic_mult_core #(.W(HALF)) u_hh (.x(s0.mag_a[WIDTH-1:HALF]), .y(s0.mag_b[WIDTH-1:HALF]), .p(hh_w));
    vedic_mult_core #(.W(HALF)) u_hl (.x(s0.mag_a[WIDTH-1:HALF]), .y(s0.mag_b[HALF-1:0]),     .p(hl_w));
    vedic_mult_core #(.W(HALF)) u_lh (.x(s0.mag_a[HALF-1:0]),     .y(s0.mag_b[WIDTH-1:HALF]), .p(lh_w));
    vedic_mult_core #(.W(HALF)) u_ll (.x(s0.mag_a[HALF-1:0]),     .y(s0.mag_b[HALF-1:0]),     .p(ll_w));

    always_comb begin
        s1_next.ctrl = s0.ctrl;
        s1_next.hh   = hh_w;
        s1_next.hl   = hl_w;
        s1_next.lh   = lh_w;
        s1_next.ll   = ll_w;
    end

    // A zero magnitude negates to zero, so a negative zero cannot appear.
    always_comb begin
        sum = {s1.hh, s1.ll}
            + ({{WIDTH{1'b0}}, s1.hl} << HALF)
            + ({{WIDTH{1'b0}}, s1.lh} << HALF);
        s2_next.ctrl = s1.ctrl;
        s2_next.prod = s1.ctrl.sign ? -sum : sum;
    end

    // NOTE: data fields are reset along with the valid bits because result
    // must read zero out of reset; these are plain flops, not a memory.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all three stages sampling the
        // pre-edge values, which is what makes this a pipeline.
        if (rst) begin
            s0 <= '0;
            s1 <= '0;
            s2 <= '0;
        end else if (advance) begin
            s0 <= s0_next;
            s1 <= s1_next;
            s2 <= s2_next;
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed self-checking bench for vedic_mult_pipe: latency, streaming,
// signed modes, backpressure, mid-flight reset and a width sweep.
module tb_vedic_mult_pipe;
    import vedic_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [15:0] a, b;
    logic [31:0] result;
    logic [31:0] exp_in;

    logic        uns_in_ready, uns_out_valid;
    logic [31:0] uns_result;

    logic        s_valid, s_sgn;
    logic [3:0]  s_a4, s_b4;
    logic [7:0]  s_a8, s_b8;
    logic [31:0] s_a32, s_b32;
    logic        s4_ir, s8_ir, s32_ir, s4_ov, s8_ov, s32_ov;
    logic [7:0]  s4_res;
    logic [15:0] s8_res;
    logic [63:0] s32_res;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_retired = 0;
    logic [31:0] exp_q[$];

    vedic_mult_pipe #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready), .result(result));

    vedic_mult_pipe #(.WIDTH(16), .SIGNED_EN(1'b0)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(uns_in_ready),
        .a(a), .b(b), .is_signed(is_signed),
        .out_valid(uns_out_valid), .out_ready(1'b1), .result(uns_result));

    vedic_mult_pipe #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s4_ir),
        .a(s_a4), .b(s_b4), .is_signed(s_sgn),
        .out_valid(s4_ov), .out_ready(1'b1), .result(s4_res));

    vedic_mult_pipe #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s8_ir),
        .a(s_a8), .b(s_b8), .is_signed(s_sgn),
        .out_valid(s8_ov), .out_ready(1'b1), .result(s8_res));

    vedic_mult_pipe #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s32_ir),
        .a(s_a32), .b(s_b32), .is_signed(s_sgn),
        .out_valid(s32_ov), .out_ready(1'b1), .result(s32_res));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Behavioural reference: sign-extend to 64 bits, multiply, keep 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input logic sg);
        logic [63:0] m, xe, ye;
        m  = (64'd1 << w) - 64'd1;
        xe = {32'd0, x} & m;
        ye = {32'd0, y} & m;
        if (sg && xe[w-1]) xe = xe | ~m;
        if (sg && ye[w-1]) ye = ye | ~m;
        return (xe * ye) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [31:0] corner(input int w, input int k);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (k)
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return m;
            default: return 32'd1 << (w - 1);
        endcase
    endfunction

    // Scoreboard on the main instance: every cycle out_valid is high the
    // result must match the oldest outstanding beat.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    check("result", result, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_retired++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(exp_in);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Presents a beat and returns just after the edge that accepted it.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic s, input logic [31:0] e);
        bit acc;
        int guard;
        a = ta; b = tb_v; is_signed = s; exp_in = e; in_valid = 1'b1;
        acc = 1'b0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            step();
            guard++;
            if (!acc && guard > 50) begin
                check("accept_timeout", in_ready, 1'b1);
                break;
            end
        end
    endtask

    task automatic sig_pair(input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic [31:0] exp_s, input logic [31:0] exp_u);
        send(ta, tb_v, 1'b1, exp_s);
        in_valid = 1'b0;
        repeat (VEDIC_LATENCY - 1) @(negedge clk);
        @(negedge clk);
        check("uns_ready", uns_in_ready, 1'b1);
        check("uns_valid", uns_out_valid, 1'b1);
        check("uns_result", uns_result, exp_u);
        step();
    endtask

    task automatic sweep(input logic [31:0] x4, input logic [31:0] y4,
                         input logic [31:0] x8, input logic [31:0] y8,
                         input logic [31:0] x32, input logic [31:0] y32,
                         input logic sg);
        s_a4 = x4[3:0];  s_b4 = y4[3:0];
        s_a8 = x8[7:0];  s_b8 = y8[7:0];
        s_a32 = x32;     s_b32 = y32;
        s_sgn = sg;      s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        repeat (VEDIC_LATENCY - 1) @(negedge clk);
        @(negedge clk);
        check("w4_valid", {s4_ov, s4_ir}, 2'b11);
        check("w8_valid", {s8_ov, s8_ir}, 2'b11);
        check("w32_valid", {s32_ov, s32_ir}, 2'b11);
        check("w4_result", {56'd0, s4_res}, ref_mul(4, x4, y4, sg));
        check("w8_result", {48'd0, s8_res}, ref_mul(8, x8, y8, sg));
        check("w32_result", s32_res, ref_mul(32, x32, y32, sg));
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ret0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        exp_in = '0; out_ready = 1'b1;
        s_valid = 1'b0; s_sgn = 1'b0; s_a4 = '0; s_b4 = '0;
        s_a8 = '0; s_b8 = '0; s_a32 = '0; s_b32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_uns_valid", uns_out_valid, 1'b0);
        step();
        rst = 1'b0;

        // Single beat latency: visible in the third cycle after acceptance.
        send(16'hFFFF, 16'h00FF, 1'b0, 32'h00FE_FF01);
        in_valid = 1'b0;
        for (int i = 1; i <= VEDIC_LATENCY; i++) begin
            @(negedge clk);
            check("latency_valid", out_valid, i == VEDIC_LATENCY);
        end
        step();
        repeat (2) step();

        // Back-to-back beats give three consecutive valid cycles.
        send(16'd11, 16'd11, 1'b0, 32'd121);
        send(16'd8,  16'd9,  1'b0, 32'd72);
        send(16'd7,  16'd7,  1'b0, 32'd49);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_valid", out_valid, i < 3);
        end
        step();
        repeat (2) step();

        // Signed on the main instance vs. SIGNED_EN = 0 on u_uns.
        sig_pair(16'hFFFF, 16'h00FF, 32'hFFFF_FF01, 32'h00FE_FF01);
        sig_pair(16'h8000, 16'h8000, 32'h4000_0000, 32'h4000_0000);
        sig_pair(16'hFFFF, 16'hFFFF, 32'h0000_0001, 32'hFFFE_0001);
        sig_pair(16'h0005, 16'hFFFD, 32'hFFFF_FFF1, 32'h0004_FFF1);
        sig_pair(16'h0000, 16'h8000, 32'h0000_0000, 32'h0000_0000);
        sig_pair(16'hFFFF, 16'h0000, 32'h0000_0000, 32'h0000_0000);
        repeat (2) step();
        check("drain_basic", exp_q.size(), 0);

        // Backpressure: consumer stalls for 4 cycles mid-stream.
        ret0 = n_retired;
        fork
            begin
                send(16'd3,      16'd5,      1'b0, 32'd15);
                send(16'h1234,   16'h0010,   1'b0, 32'h0001_2340);
                send(16'hFFFF,   16'h0002,   1'b0, 32'h0001_FFFE);
                send(16'd100,    16'd100,    1'b0, 32'd10000);
                send(16'hFFFE,   16'h0003,   1'b1, 32'hFFFF_FFFA);
                in_valid = 1'b0;
            end
            begin
                repeat (4) step();
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 1'b0);
                    check("stall_out_valid", out_valid, 1'b1);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        repeat (8) step();
        check("bp_retired", n_retired - ret0, 5);
        check("drain_bp", exp_q.size(), 0);

        // Reset while beats are in flight: none of them may ever surface.
        ret0 = n_retired;
        send(16'd21, 16'd2, 1'b0, 32'd42);
        send(16'd9,  16'd9, 1'b0, 32'd81);
        a = 16'd5; b = 16'd5; is_signed = 1'b0; exp_in = 32'd25; in_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", out_valid, 1'b0);
        step();
        repeat (6) step();
        check("rst_retired", n_retired - ret0, 0);
        send(16'd6, 16'd7, 1'b0, 32'd42);
        in_valid = 1'b0;
        repeat (5) step();
        check("post_rst_retired", n_retired - ret0, 1);
        check("drain_rst", exp_q.size(), 0);

        // Width sweep: all corner pairs in both modes, then random operands.
        for (int ka = 0; ka < 4; ka++)
            for (int kb = 0; kb < 4; kb++)
                for (int sg = 0; sg < 2; sg++)
                    sweep(corner(4, ka), corner(4, kb), corner(8, ka), corner(8, kb),
                          corner(32, ka), corner(32, kb), sg[0]);
        for (int i = 0; i < 20; i++)
            sweep($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, i[0]);

        check("final_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
